// File: rtl/ft64v8d_insn_align.sv
// FT64v8d instruction aligner: byte queue between I-cache fetch and decode, one insn per cycle.
// Optional perf counters are enabled by defining INSN_ALIGN_PERF_EN.
module ft64v8d_insn_align #(
    parameter int unsigned FETCH_BYTES = 8,
    parameter int unsigned BUF_BYTES   = 16,
    parameter int unsigned AW          = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [AW-1:0]            flush_pc_i,
    input  logic                     fetch_valid_i,
    output logic                     fetch_ready_o,
    input  logic [FETCH_BYTES*8-1:0] fetch_data_i,
    output logic [7:0]               ilen_op_o,
    input  logic [2:0]               ilen_i,
    output logic                     insn_valid_o,
    input  logic                     insn_ready_i,
    output logic [47:0]              insn_o,
    output logic [2:0]               insn_len_o,
    output logic [AW-1:0]            insn_pc_o
`ifdef INSN_ALIGN_PERF_EN
    ,
    output logic [31:0]              perf_issued_o,
    output logic [31:0]              perf_starve_o
`endif
);

    localparam int unsigned FW = FETCH_BYTES * 8;
    localparam int unsigned BW = BUF_BYTES * 8;
    localparam int unsigned OW = $clog2(FETCH_BYTES);
    localparam int unsigned CW = $clog2(BUF_BYTES + 1);

    // Queue is packed with byte 0 at the LSB; bytes at or above r_cnt are always zero.
    logic [BW-1:0] r_q;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_pc;
    logic [OW-1:0] r_dsc;

    logic [2:0]    w_elen;
    logic          w_issue;
    logic          w_accept;
    logic [47:0]   w_mask;
    logic [BW-1:0] w_q_shift;
    logic [BW-1:0] w_q_app;
    logic [BW-1:0] w_q_nxt;
    logic [FW-1:0] w_fetch_sh;
    logic [CW-1:0] w_cnt_post;
    logic [CW-1:0] w_cnt_nxt;

    assign w_elen        = (ilen_i == 3'd0 || ilen_i == 3'd7) ? 3'd1 : ilen_i;
    assign ilen_op_o     = r_q[7:0];
    assign insn_len_o    = w_elen;
    assign insn_pc_o     = r_pc;
    assign insn_valid_o  = (r_cnt >= CW'(w_elen)) && !flush_i;
    // Uses the pre-issue count so insn_ready_i never reaches fetch_ready_o.
    assign fetch_ready_o = (r_cnt <= CW'(BUF_BYTES - FETCH_BYTES)) && !flush_i;
    assign w_mask        = ~(48'hFFFF_FFFF_FFFF << {w_elen, 3'b000});
    assign insn_o        = r_q[47:0] & w_mask;
    assign w_issue       = insn_valid_o && insn_ready_i;
    assign w_accept      = fetch_valid_i && fetch_ready_o;

    always_comb begin
        w_q_shift  = w_issue ? (r_q >> {w_elen, 3'b000}) : r_q;
        w_cnt_post = r_cnt - (w_issue ? CW'(w_elen) : CW'(0));
        // Drop the leading discard bytes, then land the rest just above the post-issue tail.
        w_fetch_sh = fetch_data_i >> {r_dsc, 3'b000};
        w_q_app    = {{(BW - FW){1'b0}}, w_fetch_sh} << {w_cnt_post, 3'b000};
        w_q_nxt    = w_accept ? (w_q_shift | w_q_app) : w_q_shift;
        w_cnt_nxt  = w_cnt_post + (w_accept ? (CW'(FETCH_BYTES) - CW'(r_dsc)) : CW'(0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q   <= '0;
            r_cnt <= '0;
            r_pc  <= '0;
            r_dsc <= '0;
        end else if (flush_i) begin
            r_q   <= '0;
            r_cnt <= '0;
            r_pc  <= flush_pc_i;
            r_dsc <= flush_pc_i[OW-1:0];
        end else begin
            r_q   <= w_q_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_issue) begin
                r_pc <= r_pc + AW'(w_elen);
            end
            if (w_accept) begin
                r_dsc <= '0;
            end
        end
    end

`ifdef INSN_ALIGN_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_starve;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_issued <= '0;
            r_perf_starve <= '0;
        end else begin
            if (w_issue) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            if (insn_ready_i && !insn_valid_o && !flush_i) begin
                r_perf_starve <= r_perf_starve + 32'd1;
            end
        end
    end

    assign perf_issued_o = r_perf_issued;
    assign perf_starve_o = r_perf_starve;
`endif

endmodule

// File: tb/tb_ft64v8d_insn_align.sv
// Self-checking bench for ft64v8d_insn_align: byte-queue scoreboard plus a table of
// explicit per-cycle expectations and hand-written multi-cycle corner sequences.
module tb_ft64v8d_insn_align;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [63:0] fetch_data_i;
    logic [7:0]  ilen_op_o;
    logic [2:0]  ilen_i;
    logic        insn_valid_o;
    logic        insn_ready_i;
    logic [47:0] insn_o;
    logic [2:0]  insn_len_o;
    logic [31:0] insn_pc_o;
`ifdef INSN_ALIGN_PERF_EN
    logic [31:0] perf_issued_o;
    logic [31:0] perf_starve_o;
`endif

    ft64v8d_insn_align #(
        .FETCH_BYTES(8),
        .BUF_BYTES  (16),
        .AW         (32)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .fetch_valid_i(fetch_valid_i),
        .fetch_ready_o(fetch_ready_o),
        .fetch_data_i (fetch_data_i),
        .ilen_op_o    (ilen_op_o),
        .ilen_i       (ilen_i),
        .insn_valid_o (insn_valid_o),
        .insn_ready_i (insn_ready_i),
        .insn_o       (insn_o),
        .insn_len_o   (insn_len_o),
        .insn_pc_o    (insn_pc_o)
`ifdef INSN_ALIGN_PERF_EN
        ,
        .perf_issued_o(perf_issued_o),
        .perf_starve_o(perf_starve_o)
`endif
    );

    always #5 clk = ~clk;

    // External length decoder stand-in: E0 is a 3-byte op, otherwise low three bits.
    function automatic logic [2:0] dec(input logic [7:0] op);
        return (op == 8'hE0) ? 3'd3 : op[2:0];
    endfunction

    assign ilen_i = dec(ilen_op_o);

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  mq[$];
    logic [31:0] mpc  = 32'h0;
    int          mdsc = 0;
    logic        m_acc;

    logic        s_val;
    logic        s_rdy;
    logic [47:0] s_insn;
    logic [2:0]  s_len;
    logic [31:0] s_pc;

    typedef struct {
        logic        fl;
        logic [31:0] fpc;
        logic        fv;
        logic [63:0] d;
        logic        rdy;
        logic        ev;
        logic [2:0]  el;
        logic [31:0] ep;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic [31:0] fpc, input logic fv,
                       input logic [63:0] d, input logic rdy, input logic ev,
                       input logic [2:0] el, input logic [31:0] ep);
        vec_t v;
        v.fl = fl; v.fpc = fpc; v.fv = fv; v.d = d; v.rdy = rdy;
        v.ev = ev; v.el = el; v.ep = ep;
        tbl.push_back(v);
    endtask

    function automatic logic [63:0] wrd(input int k);
        logic [63:0] w;
        logic [1:0]  kk;
        logic [2:0]  jj;
        kk = k[1:0];
        for (int j = 0; j < 8; j++) begin
            jj = j[2:0];
            w[8*j +: 8] = {kk, jj, 3'b001};
        end
        return w;
    endfunction

    // Drive one cycle at the falling edge, compare against the byte-queue model, advance it.
    task automatic cycle(input logic fl, input logic [31:0] fpc, input logic fv,
                         input logic [63:0] d, input logic rdy);
        logic [7:0]  head;
        logic [2:0]  el;
        logic        e_rdy;
        logic        e_val;
        logic [47:0] e_insn;
        @(negedge clk);
        flush_i       = fl;
        flush_pc_i    = fpc;
        fetch_valid_i = fv;
        fetch_data_i  = d;
        insn_ready_i  = rdy;
        #1;
        head  = (mq.size() > 0) ? mq[0] : 8'h00;
        el    = dec(head);
        if (el == 3'd0 || el == 3'd7) el = 3'd1;
        e_rdy = (mq.size() <= 8) && !fl;
        e_val = (mq.size() >= int'(el)) && !fl;
        chk("ilen_op", 64'(ilen_op_o), 64'(head));
        chk("fetch_ready", 64'(fetch_ready_o), 64'(e_rdy));
        chk("insn_valid", 64'(insn_valid_o), 64'(e_val));
        if (e_val) begin
            e_insn = '0;
            for (int k = 0; k < int'(el); k++) e_insn[8*k +: 8] = mq[k];
            chk("insn_data", 64'(insn_o), 64'(e_insn));
            chk("insn_len", 64'(insn_len_o), 64'(el));
            chk("insn_pc", 64'(insn_pc_o), 64'(mpc));
        end
        s_val = insn_valid_o; s_rdy = fetch_ready_o; s_insn = insn_o;
        s_len = insn_len_o; s_pc = insn_pc_o;
        m_acc = 1'b0;
        if (fl) begin
            mq.delete();
            mpc  = fpc;
            mdsc = int'(fpc[2:0]);
        end else begin
            if (e_val && rdy) begin
                repeat (int'(el)) void'(mq.pop_front());
                mpc = mpc + {29'd0, el};
            end
            if (fv && e_rdy) begin
                for (int j = 0; j < 8; j++) if (j >= mdsc) mq.push_back(d[8*j +: 8]);
                mdsc  = 0;
                m_acc = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int first_rdy;
        logic held;

        rst_ni = 1'b0; flush_i = 1'b0; flush_pc_i = '0; fetch_valid_i = 1'b0;
        fetch_data_i = '0; insn_ready_i = 1'b0;

        // Straight-line decode, flush-entry discard, and illegal-length progress.
        add(1, 32'h1000, 0, 64'h0, 1, 0, 3'd0, 32'h0);
        add(0, 32'h0, 1, 64'h010101BB_AAE00101, 1, 0, 3'd0, 32'h0);
        add(0, 32'h0, 0, 64'h0, 1, 1, 3'd1, 32'h1000);
        add(0, 32'h0, 0, 64'h0, 1, 1, 3'd1, 32'h1001);
        add(0, 32'h0, 0, 64'h0, 1, 1, 3'd3, 32'h1002);
        add(0, 32'h0, 0, 64'h0, 1, 1, 3'd1, 32'h1005);
        add(0, 32'h0, 0, 64'h0, 1, 1, 3'd1, 32'h1006);
        add(0, 32'h0, 0, 64'h0, 1, 1, 3'd1, 32'h1007);
        add(0, 32'h0, 0, 64'h0, 1, 0, 3'd0, 32'h0);
        add(1, 32'h2005, 0, 64'h0, 1, 0, 3'd0, 32'h0);
        add(0, 32'h0, 1, 64'h010101FF_FFFFFFFF, 1, 0, 3'd0, 32'h0);
        add(0, 32'h0, 0, 64'h0, 1, 1, 3'd1, 32'h2005);
        add(0, 32'h0, 0, 64'h0, 1, 1, 3'd1, 32'h2006);
        add(0, 32'h0, 0, 64'h0, 1, 1, 3'd1, 32'h2007);
        add(0, 32'h0, 0, 64'h0, 1, 0, 3'd0, 32'h0);
        add(1, 32'h3000, 0, 64'h0, 1, 0, 3'd0, 32'h0);
        add(0, 32'h0, 1, 64'h01010101_01010700, 1, 0, 3'd0, 32'h0);
        add(0, 32'h0, 0, 64'h0, 1, 1, 3'd1, 32'h3000);
        add(0, 32'h0, 0, 64'h0, 1, 1, 3'd1, 32'h3001);

        #1;
        chk("reset_valid", 64'(insn_valid_o), 64'h0);
        chk("reset_ready", 64'(fetch_ready_o), 64'h1);
        chk("reset_insn", 64'(insn_o), 64'h0);
        chk("reset_pc", 64'(insn_pc_o), 64'h0);
        #11 rst_ni = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].fl, tbl[i].fpc, tbl[i].fv, tbl[i].d, tbl[i].rdy);
            chk("tbl_valid", 64'(s_val), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_len", 64'(s_len), 64'(tbl[i].el));
                chk("tbl_pc", 64'(s_pc), 64'(tbl[i].ep));
            end
        end

        // 6-byte instruction straddling two fetch words.
        cycle(1, 32'h4000, 0, 64'h0, 0);
        cycle(0, 32'h0, 1, 64'hA2A10601_01010101, 0);
        for (int i = 0; i < 5; i++) cycle(0, 32'h0, 0, 64'h0, 1);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 32'h0, 0, 64'h0, 1);
            chk("span_wait_valid", 64'(s_val), 64'h0);
        end
        cycle(0, 32'h0, 1, 64'hB7B6B5B4_B3B2B1B0, 1);
        chk("span_accept_valid", 64'(s_val), 64'h0);
        cycle(0, 32'h0, 0, 64'h0, 0);
        chk("span_valid", 64'(s_val), 64'h1);
        chk("span_insn", 64'(s_insn), 64'h0000_B2B1B0A2A106);
        chk("span_len", 64'(s_len), 64'h6);
        chk("span_pc", 64'(s_pc), 64'h4005);

        // Fill to capacity under backpressure, then drain and watch accept resume.
        cycle(1, 32'h5000, 0, 64'h0, 0);
        cycle(0, 32'h0, 1, wrd(0), 0);
        cycle(0, 32'h0, 1, wrd(1), 0);
        chk("second_word_ready", 64'(s_rdy), 64'h1);
        cycle(0, 32'h0, 1, wrd(2), 0);
        chk("full_ready", 64'(s_rdy), 64'h0);
        cycle(0, 32'h0, 1, wrd(2), 0);
        chk("full_ready_hold", 64'(s_rdy), 64'h0);
        first_rdy = 0;
        held = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cycle(0, 32'h0, held, wrd(2), 1);
            if (s_rdy && first_rdy == 0) first_rdy = i;
            if (m_acc) held = 1'b0;
        end
        chk("resume_cycle", 64'(first_rdy), 64'd9);
        for (int i = 0; i < 16; i++) cycle(0, 32'h0, 0, 64'h0, 1);
        chk("drain_empty", 64'(s_val), 64'h0);

        // Flush with a word on the bus at cnt=9: word dropped, queue empty next cycle.
        cycle(1, 32'h6007, 0, 64'h0, 0);
        cycle(0, 32'h0, 1, wrd(3), 0);
        cycle(0, 32'h0, 1, wrd(0), 0);
        cycle(1, 32'h6100, 1, wrd(1), 0);
        chk("flush_ready", 64'(s_rdy), 64'h0);
        chk("flush_valid", 64'(s_val), 64'h0);
        cycle(0, 32'h0, 0, 64'h0, 0);
        chk("post_flush_valid", 64'(s_val), 64'h0);
        chk("post_flush_ready", 64'(s_rdy), 64'h1);
        cycle(0, 32'h0, 1, 64'h010101BB_AAE00101, 0);
        cycle(0, 32'h0, 0, 64'h0, 0);
        chk("post_flush_pc", 64'(s_pc), 64'h6100);
        chk("post_flush_insn", 64'(s_insn), 64'h01);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        fetch_valid_i = 1'b0; insn_ready_i = 1'b0; flush_i = 1'b0;
        #1 chk("pre_reset_valid", 64'(insn_valid_o), 64'h1);
        #1 rst_ni = 1'b0;
        #1;
        chk("async_reset_valid", 64'(insn_valid_o), 64'h0);
        chk("async_reset_insn", 64'(insn_o), 64'h0);
        chk("async_reset_pc", 64'(insn_pc_o), 64'h0);
        chk("async_reset_ready", 64'(fetch_ready_o), 64'h1);
        #1 rst_ni = 1'b1;
        mq.delete();
        mpc  = 32'h0;
        mdsc = 0;
        cycle(0, 32'h0, 1, 64'h010101BB_AAE00101, 0);
        cycle(0, 32'h0, 0, 64'h0, 1);
        chk("after_reset_pc", 64'(s_pc), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
